// File: rtl/mips_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS FSM: top-level state
// encodings, opcode constants and datapath widths.
package mips_fsm_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned REG_IDX_W = 5;

    // Top FSM state encodings driven on current_state
    localparam logic [2:0] ST_FETCH      = 3'd0;
    localparam logic [2:0] ST_DECODE     = 3'd1;
    localparam logic [2:0] ST_REG_READ   = 3'd2;
    localparam logic [2:0] ST_EXECUTE    = 3'd3;
    localparam logic [2:0] ST_MEM_ACCESS = 3'd4;
    localparam logic [2:0] ST_WRITE_BACK = 3'd5;
    localparam logic [2:0] ST_OUTPUT     = 3'd6;

    // Opcodes understood by the pipeline
    localparam logic [5:0] OP_RFORM = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/memwb_mem_port.sv
// Data-memory request/acknowledge handshake with a bounded wait.
// A start while idle raises mem_req; it stays up, with address and data
// stable, until mem_ack or until MEM_TIMEOUT waiting cycles have elapsed.
module memwb_mem_port #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              start_we,
    input  logic [DATA_W-1:0] start_addr,
    input  logic [DATA_W-1:0] start_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              done,
    output logic              timeout,
    output logic [DATA_W-1:0] rdata
);

    // Counter value seen on the final permitted waiting cycle
    localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

    logic [7:0] cnt_q;

    // An ack on the last waiting cycle still counts as completion
    always_comb begin
        done    = mem_req & mem_ack;
        timeout = mem_req & ~mem_ack & (cnt_q == LAST);
        rdata   = mem_rdata;
    end

    // Request launch, hold, and release on ack or timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt_q     <= '0;
        end else if (!mem_req) begin
            if (start) begin
                mem_req   <= 1'b1;
                mem_we    <= start_we;
                mem_addr  <= start_addr;
                mem_wdata <= start_wdata;
                cnt_q     <= '0;
            end
        end else if (mem_ack || (cnt_q == LAST)) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/mem_writeback.sv
// Memory-access / write-back stage of the multi-cycle MIPS FSM.
// Latches execute's result in MEM_ACCESS, performs LW reads (and SW writes
// when MEMWB_STORE_EN is defined) over a req/ack port, writes the register
// file in WRITE_BACK and holds the final value for OUTPUT_RESULT.
// Optional feature macro: MEMWB_STORE_EN.
module mem_writeback #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned REG_IDX_W   = mips_fsm_pkg::REG_IDX_W,
    parameter int unsigned DATA_W      = mips_fsm_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           current_state,
    input  logic [5:0]           operation_code,
    input  logic [DATA_W-1:0]    execution_result,
    input  logic                 execution_result_valid,
    input  logic [REG_IDX_W-1:0] register_target_index,
    input  logic [REG_IDX_W-1:0] register_dest_index,
    input  logic [DATA_W-1:0]    register_target_value,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [DATA_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_ack,
    output logic                 rf_write_enable,
    output logic [REG_IDX_W-1:0] rf_write_index,
    output logic [DATA_W-1:0]    rf_write_data,
    output logic                 stage_busy,
    output logic                 mem_error,
    output logic [DATA_W-1:0]    output_result,
    output logic                 output_result_valid
);

    import mips_fsm_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_WAIT,
        S_WB,
        S_HOLD
    } wb_state_e;

    wb_state_e            state_q;
    logic [REG_IDX_W-1:0] dest_q;
    logic [DATA_W-1:0]    wdata_q;
    logic                 writes_q;

    logic              is_lw;
    logic              is_alu;
    logic              is_sw;
    logic              accept;
    logic              start;
    logic [DATA_W-1:0] store_data;
    logic              port_done;
    logic              port_timeout;
    logic [DATA_W-1:0] port_rdata;

`ifdef MEMWB_STORE_EN
    assign store_data = register_target_value;
`else
    // Store data has no consumer when stores are compiled out
    logic unused_store;
    assign unused_store = ^register_target_value;
    assign store_data   = '0;
`endif

    // Decode the instruction offered by execute and decide whether to take it
    always_comb begin
        is_lw  = (operation_code == OP_LW);
        is_alu = (operation_code == OP_ADDIU) || (operation_code == OP_RFORM);
`ifdef MEMWB_STORE_EN
        is_sw  = (operation_code == OP_SW);
`else
        is_sw  = 1'b0;
`endif
        accept = (state_q == S_IDLE) && (current_state == ST_MEM_ACCESS) &&
                 execution_result_valid && (is_lw || is_alu || is_sw);
        start  = accept && (is_lw || is_sw);
    end

    memwb_mem_port #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .DATA_W      (DATA_W)
    ) u_mem_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_we    (is_sw),
        .start_addr  (execution_result),
        .start_wdata (store_data),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .done        (port_done),
        .timeout     (port_timeout),
        .rdata       (port_rdata)
    );

    // The top FSM stalls exactly while a memory request is outstanding
    assign stage_busy = mem_req;

    // Stage sequencing with registered register-file and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= S_IDLE;
            dest_q              <= '0;
            wdata_q             <= '0;
            writes_q            <= 1'b0;
            rf_write_enable     <= 1'b0;
            rf_write_index      <= '0;
            rf_write_data       <= '0;
            mem_error           <= 1'b0;
            output_result       <= '0;
            output_result_valid <= 1'b0;
        end else begin
            rf_write_enable <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    output_result_valid <= 1'b0;
                    if (accept) begin
                        dest_q   <= (operation_code == OP_RFORM) ? register_dest_index
                                                                 : register_target_index;
                        wdata_q  <= is_sw ? store_data : execution_result;
                        writes_q <= !is_sw;
                        state_q  <= start ? S_MEM_WAIT : S_WB;
                    end
                end
                S_MEM_WAIT: begin
                    if (port_done) begin
                        // Stores keep their data as the reported result
                        if (writes_q) begin
                            wdata_q <= port_rdata;
                        end
                        state_q <= S_WB;
                    end else if (port_timeout) begin
                        mem_error <= 1'b1;
                        wdata_q   <= '0;
                        writes_q  <= 1'b0;
                        state_q   <= S_HOLD;
                    end
                end
                S_WB: begin
                    if (current_state == ST_WRITE_BACK) begin
                        // Register 0 is hardwired, so its writes are dropped
                        if (writes_q && (dest_q != '0)) begin
                            rf_write_enable <= 1'b1;
                            rf_write_index  <= dest_q;
                            rf_write_data   <= wdata_q;
                        end
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    output_result       <= wdata_q;
                    output_result_valid <= (current_state == ST_OUTPUT);
                    if (current_state == ST_FETCH) begin
                        output_result_valid <= 1'b0;
                        state_q             <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_writeback.sv
// Scoreboard bench for mem_writeback: a driver plays the top FSM and pushes
// expected events computed from the instruction semantics; a responder models
// data memory; a monitor pops and compares as the DUT produces events.
`timescale 1ns/1ps
module tb_mem_writeback;

    localparam int unsigned TMO = 15;
    localparam logic [5:0] OP_RFORM = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MEMWB_STORE_EN
    localparam bit STORE_EN = 1'b1;
`else
    localparam bit STORE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] current_state;
    logic [5:0] operation_code;
    logic [7:0] execution_result;
    logic       execution_result_valid;
    logic [4:0] register_target_index;
    logic [4:0] register_dest_index;
    logic [7:0] register_target_value;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       rf_write_enable;
    logic [4:0] rf_write_index;
    logic [7:0] rf_write_data;
    logic       stage_busy;
    logic       mem_error;
    logic [7:0] output_result;
    logic       output_result_valid;

    mem_writeback #(
        .MEM_TIMEOUT (TMO),
        .REG_IDX_W   (5),
        .DATA_W      (8)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .current_state          (current_state),
        .operation_code         (operation_code),
        .execution_result       (execution_result),
        .execution_result_valid (execution_result_valid),
        .register_target_index  (register_target_index),
        .register_dest_index    (register_dest_index),
        .register_target_value  (register_target_value),
        .mem_req                (mem_req),
        .mem_we                 (mem_we),
        .mem_addr               (mem_addr),
        .mem_wdata              (mem_wdata),
        .mem_rdata              (mem_rdata),
        .mem_ack                (mem_ack),
        .rf_write_enable        (rf_write_enable),
        .rf_write_index         (rf_write_index),
        .rf_write_data          (rf_write_data),
        .stage_busy             (stage_busy),
        .mem_error              (mem_error),
        .output_result          (output_result),
        .output_result_valid    (output_result_valid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] idx; logic [7:0] data; } rf_exp_t;
    typedef struct { logic [7:0] addr; logic we; logic [7:0] wdata; int dur; } mem_exp_t;
    typedef struct { int lat; logic [7:0] rdata; } resp_t;

    rf_exp_t    rf_q[$];
    mem_exp_t   mem_q[$];
    logic [7:0] out_q[$];
    resp_t      resp_q[$];
    logic       err_exp;
    logic       late_ack;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        fails++;
        $display("FAIL %s: event not expected by the model", name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_rf_we"}, rf_write_enable, 0);
        check({tag, "_rf_idx"}, rf_write_index, 0);
        check({tag, "_rf_data"}, rf_write_data, 0);
        check({tag, "_busy"}, stage_busy, 0);
        check({tag, "_mem_error"}, mem_error, 0);
        check({tag, "_out"}, output_result, 0);
        check({tag, "_out_valid"}, output_result_valid, 0);
    endtask

    // Data-memory model: acks the lat-th request cycle; lat 0 never acks.
    // Also injects stray acks while no request can be outstanding.
    initial begin
        resp_t r;
        bit    act;
        int    rcnt;
        act       = 1'b0;
        rcnt      = 0;
        r         = '{0, 8'h00};
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                if (!act) begin
                    act  = 1'b1;
                    rcnt = 0;
                    r    = (resp_q.size() != 0) ? resp_q.pop_front() : '{0, 8'h00};
                end
                rcnt++;
                if (r.lat != 0 && rcnt == r.lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = r.rdata;
                end
            end else begin
                act = 1'b0;
                if (late_ack || (current_state == 3'd5 && $urandom_range(0, 1) == 1)) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 8'($urandom);
                    late_ack  = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event
    initial begin
        mem_exp_t m;
        bit       in_req;
        int       rcount;
        logic     prev_ov;
        rf_exp_t  e;
        in_req  = 1'b0;
        rcount  = 0;
        prev_ov = 1'b0;
        m       = '{8'h00, 1'b0, 8'h00, -1};
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    rcount = 0;
                    if (mem_q.size() == 0) begin
                        flag("unexpected_mem_req");
                        m = '{8'h00, 1'b0, 8'h00, -1};
                    end else begin
                        m = mem_q.pop_front();
                    end
                end
                rcount++;
                check("mem_addr", mem_addr, m.addr);
                check("mem_we", mem_we, 32'(m.we));
                if (m.we) check("mem_wdata", mem_wdata, m.wdata);
                check("busy_during_req", stage_busy, 1);
            end else begin
                if (in_req) begin
                    check("req_cycles", rcount, m.dur);
                    in_req = 1'b0;
                end
                check("busy_without_req", stage_busy, 0);
            end
            if (rf_write_enable) begin
                if (rf_q.size() == 0) begin
                    flag("unexpected_rf_write");
                end else begin
                    e = rf_q.pop_front();
                    check("rf_index", rf_write_index, e.idx);
                    check("rf_data", rf_write_data, e.data);
                end
            end
            if (output_result_valid && !prev_ov) begin
                if (out_q.size() == 0) flag("unexpected_output_valid");
                else check("output_result", output_result, out_q.pop_front());
            end
            prev_ov = output_result_valid;
        end
    end

    task automatic step(input logic [2:0] s);
        current_state          = s;
        execution_result_valid = 1'b0;
        execution_result       = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    // One instruction through the stage; expectations come from ISA semantics
    task automatic run_txn(input logic [5:0] op, input logic [7:0] res, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [7:0] rtv, input int lat,
                           input logic [7:0] rdat);
        bit         gives_reg;
        bit         is_mem;
        bit         acked;
        logic [4:0] dst;
        logic [7:0] val;
        int         n;
        gives_reg = (op == OP_ADDIU) || (op == OP_RFORM) || (op == OP_LW);
        is_mem    = (op == OP_LW) || (STORE_EN && op == OP_SW);
        acked     = (lat != 0) && (lat <= int'(TMO));
        dst       = (op == OP_RFORM) ? rd : rt;
        if (op == OP_LW) val = acked ? rdat : 8'h00;
        else if (op == OP_SW) val = acked ? rtv : 8'h00;
        else val = res;
        if (is_mem) begin
            resp_q.push_back('{lat, rdat});
            mem_q.push_back('{res, (op == OP_SW), rtv, acked ? lat : int'(TMO)});
            if (!acked) err_exp = 1'b1;
        end
        if (gives_reg && !(op == OP_LW && !acked) && dst != 5'd0) rf_q.push_back('{dst, val});
        if (gives_reg || is_mem) out_q.push_back(val);

        step(3'd0);
        step(3'd1);
        step(3'd2);
        step(3'd3);
        current_state          = 3'd4;
        operation_code         = op;
        execution_result       = res;
        execution_result_valid = (op != OP_BEQ) && (op != OP_BNE);
        register_target_index  = rt;
        register_dest_index    = rd;
        register_target_value  = rtv;
        @(posedge clk);
        #1;
        n = 0;
        while (stage_busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) flag("busy_never_dropped");
        execution_result_valid = 1'b0;
        current_state = 3'd5;
        @(posedge clk);
        #1;
        current_state = 3'd6;
        repeat (3) @(posedge clk);
        #1;
        current_state = 3'd0;
        check("mem_error", mem_error, 32'(err_exp));
        check("rf_writes_pending", rf_q.size(), 0);
        check("outputs_pending", out_q.size(), 0);
        check("mem_reqs_pending", mem_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops[6];
        logic [5:0] op;
        logic [4:0] rt;
        logic [4:0] rd;
        ops = '{OP_ADDIU, OP_LW, OP_RFORM, OP_BEQ, OP_BNE, OP_SW};
        err_exp                = 1'b0;
        late_ack               = 1'b0;
        rst_n                  = 1'b0;
        current_state          = 3'd0;
        operation_code         = 6'd0;
        execution_result       = 8'd0;
        execution_result_valid = 1'b0;
        register_target_index  = 5'd0;
        register_dest_index    = 5'd0;
        register_target_value  = 8'd0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(OP_ADDIU, 8'h2A, 5'd3, 5'd9, 8'h00, 0, 8'h00);
        run_txn(OP_LW, 8'h10, 5'd7, 5'd1, 8'h00, 4, 8'h77);
        run_txn(OP_RFORM, 8'h05, 5'd4, 5'd0, 8'h00, 0, 8'h00);
        run_txn(OP_BEQ, 8'h33, 5'd2, 5'd2, 8'h00, 0, 8'h00);
        run_txn(OP_SW, 8'h21, 5'd5, 5'd6, 8'hC3, 3, 8'h00);
        run_txn(OP_LW, 8'h80, 5'd12, 5'd1, 8'h00, int'(TMO), 8'h5A);
        run_txn(OP_LW, 8'h40, 5'd13, 5'd1, 8'h00, 0, 8'h11);
        run_txn(OP_LW, 8'h41, 5'd14, 5'd1, 8'h00, int'(TMO) + 1, 8'h22);

        // Reset while an LW is outstanding, then a late ack
        step(3'd0);
        step(3'd1);
        step(3'd2);
        step(3'd3);
        resp_q.push_back('{0, 8'h00});
        mem_q.push_back('{8'h44, 1'b0, 8'h00, 2});
        current_state          = 3'd4;
        operation_code         = OP_LW;
        execution_result       = 8'h44;
        execution_result_valid = 1'b1;
        register_target_index  = 5'd9;
        @(posedge clk);
        #1;
        execution_result_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        err_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        current_state = 3'd0;
        rst_n         = 1'b1;
        late_ack      = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("late_ack_req", mem_req, 0);
        check("late_ack_error", mem_error, 0);
        check("late_ack_rf_we", rf_write_enable, 0);
        check("late_ack_out_valid", output_result_valid, 0);

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 5)];
            rt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_txn(op, 8'($urandom), rt, rd, 8'($urandom), $urandom_range(0, 19),
                    8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_writeback.md
Name: mem_writeback

Overview:
- Multi-cycle MIPS FSM stage directly downstream of the execute stage.
- Consumes execute's 8-bit result and valid flag during MEMORY_ACCESS and WRITE_BACK.
- Performs the LW data-memory read over a req/ack handshake with variable latency, then writes the register file.
- Holds the final value for the OUTPUT_RESULT state and stalls the top FSM while memory is outstanding.

Parameters:
- MEM_TIMEOUT, 15: max cycles waiting for mem_ack before abort; legal 1..255.
- REG_IDX_W, 5: register index width.
- DATA_W, 8: datapath width; must match execute stage.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- current_state  in  3  top FSM state: 0 fetch … 4 mem access, 5 write back, 6 output
- operation_code  in  6  instruction opcode
- execution_result  in  8  ALU result / effective address from execute
- execution_result_valid  in  1  execute produced a register-writing result
- register_target_index  in  5  rt (dest for ADDIU/LW)
- register_dest_index  in  5  rd (dest for R-form)
- register_target_value  in  8  rt value (store data, optional feature only)
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = write; always 0 without optional feature
- mem_addr  out  8  memory address
- mem_wdata  out  8  store data
- mem_rdata  in  8  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- rf_write_enable  out  1  register-file write strobe
- rf_write_index  out  5  register-file write index
- rf_write_data  out  8  register-file write data
- stage_busy  out  1  top FSM must not advance while high
- mem_error  out  1  sticky timeout flag
- output_result  out  8  value for OUTPUT_RESULT
- output_result_valid  out  1  output_result meaningful

Behaviour:
- Reset (async, rst_n=0): all outputs 0; internal state S_IDLE; timeout counter 0; mem_error cleared.
- Internal states: S_IDLE, S_MEM_WAIT, S_WB, S_HOLD.
- S_IDLE, current_state==4, execution_result_valid==1:
  - Latch opcode, result, and dest index: rt for 001001/100011, rd for 000000.
  - LW: next cycle assert mem_req=1 with mem_addr=result, stage_busy=1, go S_MEM_WAIT. Latency from state==4 to mem_req is 1 cycle.
  - Others: go S_WB, wdata=result.
- S_IDLE, current_state==4, valid==0 (BEQ/BNE/other): nothing latched; output_result_valid=0; remain S_IDLE.
- S_MEM_WAIT:
  - mem_req, mem_addr, and stage_busy held stable until mem_ack.
  - On mem_ack: capture mem_rdata, drop mem_req and stage_busy next edge, go S_WB.
  - Counter increments per waiting cycle. When it reaches MEM_TIMEOUT without ack: drop req, set mem_error=1, wdata=0, go S_HOLD with no register write.
- S_WB, current_state==5: rf_write_enable=1 for exactly one cycle with index/data. A write to index 0 is suppressed (enable stays 0). Then go S_HOLD.
- S_HOLD: output_result=write data, output_result_valid=1 while current_state==6. Return to S_IDLE when current_state==0.
- mem_ack outside S_MEM_WAIT is ignored.
- Ack arriving on the timeout cycle wins (data accepted, no error).
- Reset mid-transaction drops mem_req immediately; a late ack is ignored.
- No arithmetic here; 8-bit data passes unmodified.

Optional Feature:
- Macro MEMWB_STORE_EN.
- Defined: opcode 101011 (SW) with valid=1 issues mem_req=1, mem_we=1, mem_addr=result, mem_wdata=register_target_value. It waits for ack/timeout like LW, then performs no register write and output_result=store data.
- Undefined: SW is treated as a non-writing instruction; mem_we and mem_wdata are tied 0.

Decomposition:
- Shared package mips_fsm_pkg: top FSM state encodings 0..6, opcode constants (ADDIU, LW, BEQ, BNE, RFORM, SW), DATA_W, REG_IDX_W.
- Internal state enum local to the module.
- One natural sub-module, memwb_mem_port: req/ack handshake plus timeout counter. It exposes start, done, rdata, and timeout.

Test Plan:
- ADDIU result 0x2A, rt=3, state 4→5 → rf_write_enable pulse, index 3, data 0x2A; output_result=0x2A valid in state 6; no mem_req.
- LW address 0x10, ack after 4 cycles with rdata 0x77 → mem_req high exactly until ack, stage_busy tracks it, rf write rt data 0x77.
- LW with no ack, MEM_TIMEOUT=15 → mem_req drops after 15 waiting cycles, mem_error=1, no rf write.
- R-form to rd=0, result 0x05 → rf_write_enable stays 0; output_result=0x05.
- BEQ (valid=0) → no mem_req, no rf write, output_result_valid=0.
- LW in flight, rst_n pulsed low, late ack → all outputs 0 immediately, ack ignored, mem_error 0.
